// File: rtl/button_bank.sv
// rtl/button_bank.sv - multi-channel button synchroniser, debouncer and press/long/repeat pulse generator
// One sample strobe per sclk rise drives every channel's debounce, hold and repeat counters.
module button_bank #(
  parameter int N            = 4,
  parameter int DB_BITS      = 3,
  parameter int HOLD_TICKS   = 64,
  parameter int REPEAT_TICKS = 16,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sclk,
  input  logic [N-1:0] i,
  output logic [N-1:0] o,
  output logic [N-1:0] press,
  output logic [N-1:0] rel,
  output logic [N-1:0] long,
  output logic [N-1:0] rpt
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
  localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'((2 ** DB_BITS) - 2);
  localparam logic [HW-1:0] HOLD_V  = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD_TICKS - 1);
  localparam logic [RW-1:0] REP_M1  = RW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
  localparam bit REPEAT_ON = (REPEAT_TICKS > 0);

  logic         s1, s2, s3, tick;
  logic [N-1:0] m1, m2, x;

  // sclk is only sampled as data; the edge detector yields one tick per rise
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      m1 <= {N{ACTIVE_LOW}};
      m2 <= {N{ACTIVE_LOW}};
    end else begin
      s1 <= sclk;
      s2 <= s1;
      s3 <= s2;
      m1 <= i;
      m2 <= m1;
    end
  end

  assign tick = s2 & ~s3;
  assign x    = m2 ^ {N{ACTIVE_LOW}};

  for (genvar k = 0; k < N; k++) begin : g_ch
    logic               db;
    logic [DB_BITS-1:0] cnt;
    logic [HW-1:0]      hcnt;
    logic [RW-1:0]      rcnt;
    logic               flip, rise, fall, held, rpt_en, hit_long, hit_rpt;

    assign flip     = tick && (x[k] != db) && (cnt == DB_LAST);
    assign rise     = flip & x[k];
    assign fall     = flip & ~x[k];
    // a releasing tick never advances the hold/repeat schedule
    assign held     = tick && db && !fall;
    assign hit_long = held && (hcnt == HOLD_M1);
    assign rpt_en   = REPEAT_ON && held && (hcnt == HOLD_V);
    assign hit_rpt  = rpt_en && (rcnt == REP_M1);

    always_ff @(posedge clk) begin
      if (rst) begin
        db        <= 1'b0;
        cnt       <= '0;
        hcnt      <= '0;
        rcnt      <= '0;
        press[k]  <= 1'b0;
        rel[k]    <= 1'b0;
        long[k]   <= 1'b0;
        rpt[k]    <= 1'b0;
      end else begin
        press[k] <= rise;
        rel[k]   <= fall;
        long[k]  <= hit_long;
        rpt[k]   <= hit_rpt;
        if (tick) begin
          if (x[k] == db) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            db  <= x[k];
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        if (rise || fall) begin
          hcnt <= '0;
          rcnt <= '0;
        end else if (held) begin
          if (hcnt != HOLD_V) hcnt <= hcnt + 1'b1;
          if (hit_long || hit_rpt) rcnt <= '0;
          else if (rpt_en) rcnt <= rcnt + 1'b1;
        end
      end
    end

    assign o[k] = db;
  end

endmodule

// File: tb/tb_button_bank.sv
// tb/tb_button_bank.sv - randomized and directed check of button_bank against a tick-level reference model
module tb_button_bank;

  localparam int HOLD  = 8;
  localparam int DBMAX = 7;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       sclk = 1'b0;
  logic [1:0] i    = 2'b00;
  logic [1:0] iv   = 2'b11;
  logic [1:0] o0, press0, rel0, long0, rpt0;
  logic [1:0] o1, press1, rel1, long1, rpt1;

  int n_cmp = 0;
  int n_bad = 0;
  bit scen6 = 1'b0;
  int mdb  [2][2];
  int mrun [2][2];
  int mage [2][2];
  int mrep [2] = '{4, 0};

  always #5 clk = ~clk;

  button_bank #(.N(2), .DB_BITS(3), .HOLD_TICKS(8), .REPEAT_TICKS(4), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .i(i),
    .o(o0), .press(press0), .rel(rel0), .long(long0), .rpt(rpt0)
  );

  button_bank #(.N(2), .DB_BITS(3), .HOLD_TICKS(8), .REPEAT_TICKS(0), .ACTIVE_LOW(1'b1)) dut_v (
    .clk(clk), .rst(rst), .sclk(sclk), .i(iv),
    .o(o1), .press(press1), .rel(rel1), .long(long1), .rpt(rpt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  function automatic logic [1:0] pv(input int u, input int p);
    case (p)
      0:       return (u != 0) ? press1 : press0;
      1:       return (u != 0) ? rel1   : rel0;
      2:       return (u != 0) ? long1  : long0;
      default: return (u != 0) ? rpt1   : rpt0;
    endcase
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < 2; k++) begin
        mdb[u][k]  = 0;
        mrun[u][k] = 0;
        mage[u][k] = 0;
      end
  endtask

  // One sclk period (8 clk): inputs steady, one tick, every pulse counted per cycle.
  task automatic tick_step(input logic [1:0] a, input logic [1:0] av);
    int         cnt [2][2][4];
    int         e   [4];
    int         s;
    logic [1:0] v;
    string      nm  [4] = '{"press", "rel", "long", "rpt"};
    cnt = '{default: 0};
    i    = a;
    iv   = av;
    sclk = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (n == 4) sclk = 1'b1;
      @(negedge clk);
      for (int u = 0; u < 2; u++)
        for (int p = 0; p < 4; p++) begin
          v = pv(u, p);
          for (int k = 0; k < 2; k++) cnt[u][k][p] += int'(v[k]);
        end
      if (scen6 && press1 != 2'b00) chk("v_press_together", press1, 2'b11);
      if (scen6 && long1 != 2'b00)  chk("v_long_together", long1, 2'b11);
    end
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < 2; k++) begin
        s = (u == 0) ? int'(a[k]) : int'(!av[k]);
        e = '{default: 0};
        if (s != mdb[u][k]) mrun[u][k]++;
        else mrun[u][k] = 0;
        if (mrun[u][k] == DBMAX) begin
          mdb[u][k]  = s;
          mrun[u][k] = 0;
          mage[u][k] = 0;
          if (s != 0) e[0] = 1;
          else e[1] = 1;
        end else if (mdb[u][k] != 0) begin
          mage[u][k]++;
          if (mage[u][k] == HOLD) e[2] = 1;
          if (mrep[u] > 0 && mage[u][k] > HOLD && (mage[u][k] - HOLD) % mrep[u] == 0) e[3] = 1;
        end
        for (int p = 0; p < 4; p++)
          chk($sformatf("u%0d_%s%0d", u, nm[p], k), cnt[u][k][p], e[p]);
        v = (u != 0) ? o1 : o0;
        chk($sformatf("u%0d_o%0d", u, k), v[k], mdb[u][k]);
      end
  endtask

  task automatic do_reset(input bit rnd, input logic [1:0] a, input logic [1:0] av, input int cyc);
    rst = 1'b1;
    for (int n = 0; n < cyc; n++) begin
      if (rnd) begin
        i    = 2'($urandom_range(3));
        iv   = 2'($urandom_range(3));
        sclk = 1'($urandom_range(1));
      end else begin
        i    = a;
        iv   = av;
        sclk = 1'b0;
      end
      @(negedge clk);
      chk("rst_outs_main", {o0, press0, rel0, long0, rpt0}, 0);
      chk("rst_outs_var",  {o1, press1, rel1, long1, rpt1}, 0);
    end
    rst  = 1'b0;
    sclk = 1'b0;
    i    = a;
    iv   = av;
    @(negedge clk);
    chk("post_rst_main", {o0, press0, rel0, long0, rpt0}, 0);
    chk("post_rst_var",  {o1, press1, rel1, long1, rpt1}, 0);
    model_reset();
  endtask

  initial begin
    logic [1:0] ra, rv;
    model_reset();
    do_reset(1'b1, 2'b00, 2'b11, 6);
    // clean hold then release
    repeat (30) tick_step(2'b01, 2'b11);
    repeat (12) tick_step(2'b00, 2'b11);
    // bounce pattern never reaches the debounce threshold
    repeat (4) begin
      repeat (5) tick_step(2'b01, 2'b11);
      tick_step(2'b00, 2'b11);
    end
    repeat (20) tick_step(2'b01, 2'b11);
    // release glitch while held
    repeat (6) tick_step(2'b00, 2'b11);
    repeat (12) tick_step(2'b01, 2'b11);
    repeat (10) tick_step(2'b00, 2'b11);
    // reset while held past long
    repeat (18) tick_step(2'b01, 2'b11);
    do_reset(1'b0, 2'b01, 2'b11, 3);
    repeat (20) tick_step(2'b01, 2'b11);
    repeat (10) tick_step(2'b00, 2'b11);
    // variant: both active-low channels pressed together, no repeat
    scen6 = 1'b1;
    repeat (24) tick_step(2'b00, 2'b00);
    scen6 = 1'b0;
    repeat (10) tick_step(2'b00, 2'b11);
    // random slow-changing levels on every channel
    ra = 2'b00;
    rv = 2'b11;
    for (int t = 0; t < 200; t++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(5) == 0) ra[k] = ~ra[k];
        if ($urandom_range(5) == 0) rv[k] = ~rv[k];
      end
      tick_step(ra, rv);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_bank.md
# button_bank

Multi-channel button conditioner, the parametrised successor to the single-channel debounce/sync and pulse blocks. It synchronises N raw button inputs into the `clk` domain and debounces both press and release against a slow sample strobe derived from a `clockDiv` bit. Per channel it emits a level, press and release pulses, a long-press pulse and an auto-repeat pulse train. It sits between the board pins and any UI/control FSM.

## Interface
- `N`, 4: channel count.
- `DB_BITS`, 3: debounce counter width; `DB_MAX = 2**DB_BITS - 1` consecutive disagreeing ticks are needed to change state.
- `HOLD_TICKS`, 64: ticks after the press edge until the long-press pulse; must be ≥ 1.
- `REPEAT_TICKS`, 16: ticks between repeat pulses after the long press; 0 disables repeat.
- `ACTIVE_LOW`, 0: 1 means the raw input reads 0 when pressed.

- `clk` input 1: sole clock; all flops on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sclk` input 1: slow divided clock (a `clockDiv` output bit), treated as data and never used as a clock.
- `i` input N: raw, asynchronous button levels.
- `o` output N: debounced level, 1 = pressed.
- `press` output N: one-`clk` pulse on the debounced rising edge.
- `release` output N: one-`clk` pulse on the debounced falling edge.
- `long` output N: one-`clk` pulse on reaching the long-press threshold.
- `rpt` output N: one-`clk` auto-repeat pulses.

## Operation
- **sclk strobe.** `sclk` passes through a 3-flop chain `s1`→`s2`→`s3`, all reset to 0. `tick = s2 & ~s3`, so there is one `clk` pulse per `sclk` rise. If `sclk` is already high at reset release, a tick occurs.
- **Input sync.** Each `i[k]` passes through 2 flops that reset to the idle level (`ACTIVE_LOW`). The result is then XORed with `ACTIVE_LOW` to give the sample `x[k]`, where 1 = pressed.
- **Debounce (symmetric).** State is `db[k]` plus `cnt[k]` (`DB_BITS` wide). The following applies on tick only:
  - if `x == db`: `cnt ← 0`.
  - else if `cnt == DB_MAX-1`: `db ← x`, `cnt ← 0`.
  - else: `cnt ← cnt+1`.
  - A single agreeing sample restarts the count.
- **Outputs.**
  - `o = db` (registered).
  - `press`/`release` are registered on the same edge that `db` changes, so `press` is high exactly during the first cycle of `o=1`.
- **Hold counter.** `hcnt[k]` is wide enough to hold `HOLD_TICKS`.
  - Cleared on the press edge.
  - On each later tick with `db=1` and `hcnt<HOLD_TICKS`: `hcnt+1`. The tick where it becomes `HOLD_TICKS` asserts `long`, after which it saturates.
- **Repeat counter.** `rcnt[k]` is cleared when `long` fires.
  - On each later tick with `db=1`: increment.
  - On reaching `REPEAT_TICKS`: assert `rpt` and set `rcnt ← 0`.
  - Inactive when `REPEAT_TICKS=0`.
- **Release.** On the tick where `db` goes 1→0, `hcnt` and `rcnt` clear, and `long`/`rpt` are suppressed on that tick even if a threshold would have been hit.
- **Channel independence.** Channels are fully independent; simultaneous events on multiple channels each pulse in the same cycle.
- **No pulse overlap.** `press` and `long` can never coincide, because `HOLD_TICKS ≥ 1`.

## Timing
- **Reset.** While `rst=1`, and on the cycle after, every output (`o`, `press`, `release`, `long`, `rpt`) is 0, as are all counters, `db`, and the strobe chain.
- **Reset mid-operation.** Reset while a channel is held clears it with no `release` pulse. After reset, a still-held button re-presses after `DB_MAX` ticks.
- **Latency.**
  - `sclk` rise to `tick`: 2–3 `clk` cycles.
  - `i` change to the sample: 2 `clk` cycles.
  - `o` changes on the `DB_MAX`-th consecutive disagreeing tick; the default is 7 ticks.
- **Pulse widths.** All pulses are exactly 1 `clk` wide, and at most one of each per tick per channel.
- **Thresholds.** `long` occurs `HOLD_TICKS` ticks after the `press` tick. The first `rpt` occurs `REPEAT_TICKS` ticks after `long`, and repeats every `REPEAT_TICKS` ticks.

## Test plan
Test setup for all scenarios unless stated otherwise:
- `N=2`, `DB_BITS=3`, `HOLD_TICKS=8`, `REPEAT_TICKS=4`, `ACTIVE_LOW=0`.
- `sclk` toggles every 4 `clk`, giving a tick every 8 `clk`.

1. **Reset.** Assert `rst` with random `i`/`sclk` → all outputs 0 throughout reset and on the first cycle after.
2. **Clean hold.**
   - Stimulus: `i[0]=1` held for 30 ticks, then 0.
   - `o[0]` rises with a 1-cycle `press` on the 7th tick.
   - `long` on the 8th tick after `press`.
   - `rpt` at +12, +16, +20 … ticks after `press`.
   - After `i` drops: `o` falls with one `release` on the 7th tick; no `long`/`rpt` afterwards.
3. **Bounce.** `i[0]` pattern of 1 for 5 ticks, 0 for 1 tick, repeated 4 times → no `press`, `o[0]` stays 0. Then steady 1 → `press` on the 7th tick.
4. **Release glitch.** While held, `i[0]=0` for 6 ticks then 1 → no `release`; `o` stays 1; `long`/`rpt` continue on schedule.
5. **Reset mid-hold.** `rst` pulse after `long` while `i[0]=1` → all outputs 0, no `release`. After reset with `i[0]` still 1: `press` 7 ticks later, `long` 8 ticks after that.
6. **Variant build.**
   - Parameters: `ACTIVE_LOW=1`, `REPEAT_TICKS=0`.
   - Stimulus: drive `i=2'b00` (both pressed) on the same cycle.
   - Expected: `press[1:0]=2'b11` in the same cycle; `long` on both channels together; never any `rpt`.
